fir_interp_poly: RTL and testbench
==================================

# fir_interp_poly

Parametrised polyphase interpolating FIR, the successor to `fir_direct_pipe`. It accepts one signed input sample per handshake and emits `INTERP_FACTOR` filtered output samples, one per polyphase branch. It adds valid/ready flow control on both sides, rounding and saturation. It sits between the sample source and the DAC-side datapath of the interpolation chain.

## Interface
- `DATA_WIDTH`, 5: signed input/output sample width.
- `TAP_COEFF_WIDTH`, 5: signed coefficient width.
- `NUM_TAPS`, 48: prototype filter length; must be a multiple of `INTERP_FACTOR` (elaboration-time `$error` otherwise).
- `INTERP_FACTOR`, 4: upsampling factor L, ≥ 2.
- `OUT_SHIFT`, `TAP_COEFF_WIDTH-1`: arithmetic right shift applied to the accumulator before rounding and saturation.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  block can accept `in` this cycle.
- `in`  in  `DATA_WIDTH`  signed input sample.
- `out_valid`  out  1  `out` holds a valid sample.
- `out_ready`  in  1  downstream consumes `out` this cycle.
- `out`  out  `DATA_WIDTH`  signed interpolated sample.
- `tap_coeffs`  in  `TAP_COEFF_WIDTH*NUM_TAPS`  flattened coefficients; tap i occupies `[TAP_COEFF_WIDTH*(i+1)-1 : TAP_COEFF_WIDTH*i]`; quasi-static.

## Operation
- P = `NUM_TAPS/INTERP_FACTOR` taps per phase. The delay line holds x[n]…x[n-P+1].
- Phase k computes y[nL+k] = Σ_{j=0..P-1} h[jL+k]·x[n-j], for k = 0..L-1, emitted in ascending k.
- Arithmetic:
  - Each product is full precision (`DATA_WIDTH+TAP_COEFF_WIDTH` bits).
  - Accumulator width is `DATA_WIDTH+TAP_COEFF_WIDTH+$clog2(P)`; it never overflows.
  - Result = (acc + (`OUT_SHIFT`>0 ? 1<<(`OUT_SHIFT`-1) : 0)) >>> `OUT_SHIFT`, which is round-half-up.
  - The result then saturates to the signed `DATA_WIDTH` range.
- FSM states:
  - IDLE: `in_ready`=1. On accept, shift `in` into the delay line, set phase=0, go to RUN.
  - RUN: `slot_free` = !`out_valid` || `out_ready`. When `slot_free`, register the phase result into `out`, set `out_valid`=1, and increment phase.
    - If phase is L-1 and there is no accept, go to IDLE.
    - If phase is L-1 and an accept happens in the same cycle, stay in RUN with phase=0.
  - `in_ready` = !`rst` && (IDLE || (RUN && phase==L-1 && `slot_free`)).
- Simultaneous last-phase load and accept: the phase result uses the pre-shift delay line; the shift takes effect at the same edge.
- In IDLE with `out_valid`=1 and `out_ready`=1: `out_valid` drops to 0.
- Backpressure (`out_ready`=0 with `out_valid`=1):
  - `out` is held stable.
  - The phase counter does not advance.
  - No sample is lost or duplicated.
- Reset (synchronous, at any time):
  - delay line cleared to 0;
  - state IDLE, phase 0;
  - `out_valid`=0, `out`=0;
  - any partially emitted burst is discarded.

## Timing
- Latency: input accepted at cycle t → phase 0 registered at the end of t+1 → `out_valid`=1 during t+2.
- Steady state with `out_ready`=1: one input every L cycles; `out_valid` stays continuously high; throughput is one output per cycle.
- Reset values: `out_valid`=0, `out`=0, `in_ready`=0 while `rst`=1 and 1 on the first cycle after.
- `tap_coeffs` changes take effect on the next phase computed; there is no per-burst coherency guarantee.

## Structure
- Package `fir_pkg`:
  - `ACC_WIDTH` and P computation functions;
  - `sat_round` function (shift, round, saturate);
  - FSM state enum `fir_state_e` {IDLE, RUN}.
- Sub-module `fir_phase_mac`: combinational P-tap dot product. It takes the delay line and the strided coefficient slice for phase k, and returns the `ACC_WIDTH` sum.
- Top level contains the FSM, phase counter, delay line and output register.

## Test plan
All tests use L=2, `NUM_TAPS`=8, 5-bit data and coefficients.
- Impulse: h[i]=i+1, `OUT_SHIFT`=0, inputs 1,0,0,0,… with `out_ready`=1 → `out` = 1,2,3,4,5,6,7,8, then 0s. First `out_valid` is 2 cycles after the first accept.
- Saturation: all h=15, `OUT_SHIFT`=0.
  - Constant x=15 → after fill, `out`=15.
  - Constant x=-16 → after fill, `out`=-16.
- Rounding: `OUT_SHIFT`=1, h[0]=1, others 0.
  - x=3 → phase-0 `out`=2.
  - x=-3 → phase-0 `out`=-1.
  - Phase-1 `out` is 0 in both cases.
- Backpressure: impulse test, with `out_ready`=0 for 3 cycles while `out`=3 → `out` holds 3 and `in_ready`=0 throughout; the sequence resumes 4,5,… with no gaps or duplicates.
- Streaming: `in_valid`=1 and `out_ready`=1 continuously → `in_ready` pulses every 2nd cycle; `out_valid` stays 1 from cycle 2 on.
- Reset mid-burst: assert `rst` after `out`=5 → `out_valid`=0 and `out`=0 the next cycle; a new impulse then yields exactly 1..8 with no residue from before the reset.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the polyphase interpolating FIR.
package fir_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fir_state_e;

  // Width used by the rounding/saturation helper; wide enough for any accumulator here.
  localparam int SR_W = 64;

  // Taps per polyphase branch.
  function automatic int calc_p(input int num_taps, input int interp);
    return num_taps / interp;
  endfunction

  // Accumulator width that holds a full P-term sum of products without overflow.
  function automatic int calc_acc_width(input int dw, input int cw, input int p);
    return dw + cw + $clog2(p);
  endfunction

  // Round-half-up arithmetic right shift followed by saturation to a dw-bit signed range.
  function automatic logic signed [SR_W-1:0] sat_round(input logic signed [SR_W-1:0] acc,
                                                       input int shift, input int dw);
    logic signed [SR_W-1:0] bias;
    logic signed [SR_W-1:0] res;
    logic signed [SR_W-1:0] max_v;
    logic signed [SR_W-1:0] min_v;
    if (shift > 0) begin
      bias = 64'sd1 <<< (shift - 1);
    end else begin
      bias = 64'sd0;
    end
    res   = (acc + bias) >>> shift;
    max_v = (64'sd1 <<< (dw - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (dw - 1));
    if (res > max_v) begin
      sat_round = max_v;
    end else if (res < min_v) begin
      sat_round = min_v;
    end else begin
      sat_round = res;
    end
  endfunction

endpackage

// File: rtl/fir_interp_poly_mac.sv
// Combinational P-tap dot product for one polyphase branch.
module fir_phase_mac
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH      = 5,
  parameter int TAP_COEFF_WIDTH = 5,
  parameter int P               = 12,
  parameter int ACC_WIDTH       = calc_acc_width(DATA_WIDTH, TAP_COEFF_WIDTH, P)
) (
  input  logic [DATA_WIDTH*P-1:0]      x_line,
  input  logic [TAP_COEFF_WIDTH*P-1:0] h_phase,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  localparam int PROD_WIDTH = DATA_WIDTH + TAP_COEFF_WIDTH;

  logic signed [PROD_WIDTH-1:0] prod_s;
  logic signed [ACC_WIDTH-1:0]  sum_s;

  // Sum of full-precision signed products x[n-j]*h[jL+k].
  always_comb begin
    sum_s  = '0;
    prod_s = '0;
    for (int j = 0; j < P; j++) begin
      prod_s = PROD_WIDTH'($signed(x_line[DATA_WIDTH*j +: DATA_WIDTH])) *
               PROD_WIDTH'($signed(h_phase[TAP_COEFF_WIDTH*j +: TAP_COEFF_WIDTH]));
      sum_s  = sum_s + ACC_WIDTH'(prod_s);
    end
  end

  assign acc = sum_s;

endmodule

// File: rtl/fir_interp_poly.sv
// Polyphase interpolating FIR: one input per handshake, INTERP_FACTOR outputs per input.
module fir_interp_poly
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH      = 5,
  parameter int TAP_COEFF_WIDTH = 5,
  parameter int NUM_TAPS        = 48,
  parameter int INTERP_FACTOR   = 4,
  parameter int OUT_SHIFT       = TAP_COEFF_WIDTH - 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [DATA_WIDTH-1:0]        in,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [DATA_WIDTH-1:0]        out,
  input  logic [TAP_COEFF_WIDTH*NUM_TAPS-1:0] tap_coeffs
);

  localparam int P         = calc_p(NUM_TAPS, INTERP_FACTOR);
  localparam int ACC_WIDTH = calc_acc_width(DATA_WIDTH, TAP_COEFF_WIDTH, P);
  localparam int PH_W      = $clog2(INTERP_FACTOR);
  localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(INTERP_FACTOR - 1);

  if (NUM_TAPS % INTERP_FACTOR != 0) begin : g_bad_taps
    $error("NUM_TAPS must be a multiple of INTERP_FACTOR");
  end
  if (INTERP_FACTOR < 2) begin : g_bad_interp
    $error("INTERP_FACTOR must be at least 2");
  end

  fir_state_e                     state_r, state_n_s;
  logic [PH_W-1:0]                phase_r, phase_n_s;
  logic signed [DATA_WIDTH-1:0]   dline_r [P];
  logic                           out_valid_r, out_valid_n_s;
  logic signed [DATA_WIDTH-1:0]   out_r;
  logic                           slot_free_s, last_s, accept_s, in_ready_s, load_s;
  logic [DATA_WIDTH*P-1:0]        x_flat_s;
  logic [TAP_COEFF_WIDTH*P-1:0]   h_sel_s;
  logic signed [ACC_WIDTH-1:0]    acc_s;
  logic signed [SR_W-1:0]         acc_ext_s;
  logic signed [DATA_WIDTH-1:0]   result_s;

  // Flatten the delay line and pick the strided coefficients h[jL+phase].
  always_comb begin
    x_flat_s = '0;
    h_sel_s  = '0;
    for (int j = 0; j < P; j++) begin
      x_flat_s[DATA_WIDTH*j +: DATA_WIDTH] = dline_r[j];
      h_sel_s[TAP_COEFF_WIDTH*j +: TAP_COEFF_WIDTH] =
        tap_coeffs[TAP_COEFF_WIDTH*(j*INTERP_FACTOR + int'(phase_r)) +: TAP_COEFF_WIDTH];
    end
  end

  fir_phase_mac #(
    .DATA_WIDTH     (DATA_WIDTH),
    .TAP_COEFF_WIDTH(TAP_COEFF_WIDTH),
    .P              (P),
    .ACC_WIDTH      (ACC_WIDTH)
  ) u_mac (
    .x_line (x_flat_s),
    .h_phase(h_sel_s),
    .acc    (acc_s)
  );

  assign acc_ext_s = SR_W'(acc_s);
  assign result_s  = DATA_WIDTH'(sat_round(acc_ext_s, OUT_SHIFT, DATA_WIDTH));

  // Handshake qualifiers: output slot availability and input acceptance.
  always_comb begin
    slot_free_s = !out_valid_r || out_ready;
    last_s      = (phase_r == LAST_PHASE);
    in_ready_s  = !rst && ((state_r == IDLE) ||
                           ((state_r == RUN) && last_s && slot_free_s));
    accept_s    = in_valid && in_ready_s;
  end

  // Next-state, phase advance and output-load decisions.
  always_comb begin
    state_n_s     = state_r;
    phase_n_s     = phase_r;
    out_valid_n_s = out_valid_r;
    load_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_n_s = RUN;
          phase_n_s = '0;
        end else begin
          state_n_s = IDLE;
        end
        if (out_valid_r && out_ready) begin
          out_valid_n_s = 1'b0;
        end else begin
          out_valid_n_s = out_valid_r;
        end
      end
      RUN: begin
        if (slot_free_s) begin
          load_s        = 1'b1;
          out_valid_n_s = 1'b1;
          if (last_s) begin
            phase_n_s = '0;
            if (accept_s) begin
              state_n_s = RUN;
            end else begin
              state_n_s = IDLE;
            end
          end else begin
            phase_n_s = phase_r + PH_W'(1'b1);
          end
        end else begin
          load_s = 1'b0;
        end
      end
      default: begin
        state_n_s     = IDLE;
        phase_n_s     = '0;
        out_valid_n_s = 1'b0;
      end
    endcase
  end

  // FSM state, phase counter and registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      phase_r     <= '0;
      out_valid_r <= 1'b0;
      out_r       <= '0;
    end else begin
      state_r     <= state_n_s;
      phase_r     <= phase_n_s;
      out_valid_r <= out_valid_n_s;
      if (load_s) begin
        out_r <= result_s;
      end
    end
  end

  // Delay line: newest sample at index 0; a same-edge phase load still sees the old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < P; j++) begin
        dline_r[j] <= '0;
      end
    end else if (accept_s) begin
      dline_r[0] <= in;
      for (int j = 1; j < P; j++) begin
        dline_r[j] <= dline_r[j-1];
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out       = out_r;

endmodule

// File: tb/tb_fir_interp_poly.sv
// Self-checking bench: two instances (OUT_SHIFT 0 and 1) share stimulus; a queue-based
// reference model computes each output directly from the interpolation equation.
module tb_fir_interp_poly;

  localparam int DW = 5;
  localparam int CW = 5;
  localparam int NT = 8;
  localparam int L  = 2;
  localparam int P  = NT / L;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                out_ready = 1'b0;
  logic signed [DW-1:0] in_d = '0;
  logic [CW*NT-1:0]    coeffs = '0;
  logic                ir0, ov0, ir1, ov1;
  logic signed [DW-1:0] o0, o1;

  int total = 0;
  int bad   = 0;
  int n_acc = 0;
  int h_m[NT];
  int xs[$];
  int q0[$];
  int q1[$];

  logic                s_ir0, s_ov0, s_ir1, s_ov1;
  logic signed [DW-1:0] s_o0, s_o1;
  logic                s_acc, s_cons, e_ok;
  int                  e0, e1;

  always #5 clk = ~clk;

  fir_interp_poly #(.DATA_WIDTH(DW), .TAP_COEFF_WIDTH(CW), .NUM_TAPS(NT),
                    .INTERP_FACTOR(L), .OUT_SHIFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in(in_d),
    .out_valid(ov0), .out_ready(out_ready), .out(o0), .tap_coeffs(coeffs));

  fir_interp_poly #(.DATA_WIDTH(DW), .TAP_COEFF_WIDTH(CW), .NUM_TAPS(NT),
                    .INTERP_FACTOR(L), .OUT_SHIFT(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in(in_d),
    .out_valid(ov1), .out_ready(out_ready), .out(o1), .tap_coeffs(coeffs));

  // y[nL+k] = sum_j h[jL+k]*x[n-j], then round-half-up shift and clamp.
  function automatic int exp_y(input int k, input int s);
    int acc;
    int idx;
    int r;
    acc = 0;
    for (int j = 0; j < P; j++) begin
      idx = xs.size() - 1 - j;
      if (idx >= 0) acc += h_m[j*L + k] * xs[idx];
    end
    if (s > 0) acc += (1 << (s - 1));
    r = acc >>> s;
    if (r > 15) r = 15;
    if (r < -16) r = -16;
    return r;
  endfunction

  task automatic set_coeffs();
    for (int i = 0; i < NT; i++) coeffs[CW*i +: CW] = CW'(h_m[i]);
  endtask

  task automatic rand_coeffs();
    for (int i = 0; i < NT; i++) h_m[i] = int'($urandom_range(31, 0)) - 16;
    set_coeffs();
  endtask

  task automatic impulse_coeffs();
    for (int i = 0; i < NT; i++) h_m[i] = i + 1;
    set_coeffs();
  endtask

  // One clock: sample at negedge, update model with the handshakes of the coming edge.
  task automatic tick();
    @(negedge clk);
    s_ir0 = ir0; s_ov0 = ov0; s_o0 = o0;
    s_ir1 = ir1; s_ov1 = ov1; s_o1 = o1;
    s_acc  = in_valid && ir0 && !rst;
    s_cons = ov0 && out_ready && !rst;
    e_ok   = 1'b0;
    if (rst) begin
      xs.delete(); q0.delete(); q1.delete();
      n_acc = 0;
    end else begin
      if (s_cons && q0.size() > 0) begin
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        e_ok = 1'b1;
      end
      if (s_acc) begin
        xs.push_back(int'(in_d));
        n_acc++;
        for (int k = 0; k < L; k++) begin
          q0.push_back(exp_y(k, 0));
          q1.push_back(exp_y(k, 1));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    total++; if (s_ir0 !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", s_ir0); end
    total++; if (s_ov0 !== 1'b0 || s_ov1 !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b/%b want 0", s_ov0, s_ov1); end
    total++; if (s_o0 !== 5'sd0 || s_o1 !== 5'sd0) begin bad++; $display("FAIL reset_out: got %0d/%0d want 0", s_o0, s_o1); end
    rst = 1'b0;
    tick();
    total++; if (s_ir0 !== 1'b1 || s_ir1 !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b/%b want 1", s_ir0, s_ir1); end
  endtask

  task automatic test_impulse();
    int first_acc, first_ov, seen, want;
    impulse_coeffs(); do_reset(); out_ready = 1'b1;
    first_acc = -1; first_ov = -1; seen = 0;
    for (int c = 0; c < 40; c++) begin
      in_valid = (n_acc < 6);
      in_d = (n_acc == 0) ? 5'sd1 : 5'sd0;
      tick();
      if (s_acc && first_acc < 0) first_acc = c;
      if (s_ov0 && first_ov < 0) first_ov = c;
      if (s_cons) begin
        want = (seen < 8) ? seen + 1 : 0;
        total++;
        if (!e_ok || s_o0 !== want || s_o1 !== e1) begin
          bad++; $display("FAIL impulse_out[%0d]: got %0d/%0d want %0d/%0d", seen, s_o0, s_o1, want, e1);
        end
        seen++;
      end
    end
    total++; if (first_ov - first_acc != 2) begin bad++; $display("FAIL impulse_latency: got %0d want 2", first_ov - first_acc); end
    total++; if (seen != 12) begin bad++; $display("FAIL impulse_count: got %0d want 12", seen); end
  endtask

  task automatic test_saturation();
    logic signed [DW-1:0] last0, last1;
    for (int i = 0; i < NT; i++) h_m[i] = 15;
    set_coeffs(); do_reset(); out_ready = 1'b1;
    last0 = '0; last1 = '0;
    for (int seg = 0; seg < 2; seg++) begin
      for (int c = 0; c < 40; c++) begin
        in_valid = (n_acc < 10 * (seg + 1));
        in_d = (seg == 0) ? 5'sd15 : -5'sd16;
        tick();
        if (s_cons) begin
          total++;
          if (!e_ok || s_o0 !== e0 || s_o1 !== e1) begin
            bad++; $display("FAIL sat_out: got %0d/%0d want %0d/%0d", s_o0, s_o1, e0, e1);
          end
          last0 = s_o0; last1 = s_o1;
        end
      end
      total++;
      if (seg == 0 && (last0 !== 5'sd15 || last1 !== 5'sd15)) begin
        bad++; $display("FAIL sat_pos: got %0d/%0d want 15", last0, last1);
      end else if (seg == 1 && (last0 !== -5'sd16 || last1 !== -5'sd16)) begin
        bad++; $display("FAIL sat_neg: got %0d/%0d want -16", last0, last1);
      end
    end
  endtask

  task automatic test_rounding();
    int want0[8] = '{3, 0, -3, 0, 0, 0, 0, 0};
    int want1[8] = '{2, 0, -1, 0, 0, 0, 0, 0};
    int seen;
    for (int i = 0; i < NT; i++) h_m[i] = (i == 0) ? 1 : 0;
    set_coeffs(); do_reset(); out_ready = 1'b1; seen = 0;
    for (int c = 0; c < 30; c++) begin
      in_valid = (n_acc < 4);
      in_d = (n_acc == 0) ? 5'sd3 : ((n_acc == 1) ? -5'sd3 : 5'sd0);
      tick();
      if (s_cons && seen < 8) begin
        total++;
        if (!e_ok || s_o0 !== want0[seen] || s_o1 !== want1[seen] || s_o1 !== e1) begin
          bad++; $display("FAIL round_out[%0d]: got %0d/%0d want %0d/%0d", seen, s_o0, s_o1, want0[seen], want1[seen]);
        end
        seen++;
      end
    end
    total++; if (seen != 8) begin bad++; $display("FAIL round_count: got %0d want 8", seen); end
  endtask

  task automatic test_backpressure();
    int seen, hold, want;
    impulse_coeffs(); do_reset(); seen = 0; hold = 0;
    for (int c = 0; c < 60; c++) begin
      in_valid = (n_acc < 6);
      in_d = (n_acc == 0) ? 5'sd1 : 5'sd0;
      out_ready = !(seen == 2 && hold < 3);
      tick();
      if (!out_ready) begin
        hold++;
        total++;
        if (s_ov0 !== 1'b1 || s_o0 !== 5'sd3 || s_ir0 !== 1'b0) begin
          bad++; $display("FAIL bp_hold: got v=%b out=%0d rdy=%b want v=1 out=3 rdy=0", s_ov0, s_o0, s_ir0);
        end
      end
      if (s_cons) begin
        want = (seen < 8) ? seen + 1 : 0;
        total++;
        if (!e_ok || s_o0 !== want || s_o1 !== e1) begin
          bad++; $display("FAIL bp_out[%0d]: got %0d/%0d want %0d/%0d", seen, s_o0, s_o1, want, e1);
        end
        seen++;
      end
    end
    total++; if (hold != 3 || seen != 12) begin bad++; $display("FAIL bp_count: got hold=%0d n=%0d want 3/12", hold, seen); end
  endtask

  task automatic test_streaming();
    rand_coeffs(); do_reset(); out_ready = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      in_d = DW'($urandom);
      tick();
      total++;
      if (s_ir0 !== ((c % 2) == 0) || s_ir1 !== ((c % 2) == 0)) begin
        bad++; $display("FAIL stream_ready[%0d]: got %b/%b want %b", c, s_ir0, s_ir1, (c % 2) == 0);
      end
      if (c >= 2) begin
        total++;
        if (s_ov0 !== 1'b1 || s_ov1 !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d]: got %b/%b want 1", c, s_ov0, s_ov1); end
      end
      if (s_cons) begin
        total++;
        if (!e_ok || s_o0 !== e0 || s_o1 !== e1) begin bad++; $display("FAIL stream_out: got %0d/%0d want %0d/%0d", s_o0, s_o1, e0, e1); end
      end
    end
  endtask

  task automatic test_random();
    rand_coeffs(); do_reset();
    for (int c = 0; c < 420; c++) begin
      in_valid  = (c < 400) ? ($urandom_range(1, 0) == 1) : 1'b0;
      out_ready = (c < 400) ? ($urandom_range(3, 0) != 0) : 1'b1;
      in_d = DW'($urandom);
      tick();
      if (s_cons) begin
        total++;
        if (!e_ok || s_o0 !== e0 || s_o1 !== e1) begin bad++; $display("FAIL rand_out: got %0d/%0d want %0d/%0d", s_o0, s_o1, e0, e1); end
      end
    end
    total++; if (q0.size() != 0) begin bad++; $display("FAIL rand_drain: got %0d pending want 0", q0.size()); end
  endtask

  task automatic test_reset_midburst();
    int seen, want;
    logic found;
    impulse_coeffs(); do_reset(); out_ready = 1'b1; found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      in_valid = (n_acc < 6);
      in_d = (n_acc == 0) ? 5'sd1 : 5'sd0;
      tick();
      if (s_cons) begin
        total++;
        if (!e_ok || s_o0 !== e0) begin bad++; $display("FAIL mid_pre_out: got %0d want %0d", s_o0, e0); end
        if (s_o0 == 5'sd5) found = 1'b1;
      end
    end
    total++; if (!found) begin bad++; $display("FAIL mid_reach5: got timeout want out=5"); end
    rst = 1'b1; in_valid = 1'b0;
    tick(); tick();
    total++;
    if (s_ov0 !== 1'b0 || s_o0 !== 5'sd0 || s_ov1 !== 1'b0 || s_o1 !== 5'sd0) begin
      bad++; $display("FAIL mid_reset: got v=%b out=%0d want v=0 out=0", s_ov0, s_o0);
    end
    rst = 1'b0; seen = 0;
    for (int c = 0; c < 40; c++) begin
      in_valid = (n_acc < 6);
      in_d = (n_acc == 0) ? 5'sd1 : 5'sd0;
      tick();
      if (s_cons) begin
        want = (seen < 8) ? seen + 1 : 0;
        total++;
        if (!e_ok || s_o0 !== want || s_o1 !== e1) begin
          bad++; $display("FAIL mid_post_out[%0d]: got %0d want %0d", seen, s_o0, want);
        end
        seen++;
      end
    end
    total++; if (seen != 12) begin bad++; $display("FAIL mid_post_count: got %0d want 12", seen); end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_saturation();
    test_rounding();
    test_backpressure();
    test_streaming();
    test_random();
    test_reset_midburst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
